// File: rtl/uart_pkg.sv
// Shared encodings for the UART engine: parity modes, TX/RX FSM states,
// idle line level and parity helpers.
`timescale 1ns/1ps
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // The reserved encoding 2'b11 behaves exactly like "no parity".
  function automatic logic [1:0] norm_parity(input logic [1:0] mode);
    return ((mode == PAR_EVEN) || (mode == PAR_ODD)) ? mode : PAR_NONE;
  endfunction

  function automatic logic parity_of(input logic [8:0] data, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud tick divider shared by the TX and RX paths.
`timescale 1ns/1ps
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic             w_wrap;

  assign w_wrap = (r_cnt == r_div);
  assign o_tick = w_wrap;

  // The divisor is only reloaded at wrap so a running period is never cut short.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_div <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_div <= i_div;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_core_p.sv
// Full-duplex UART engine with oversampling receiver and holding register.
// Optional macro UART_LOOPBACK_EN adds cfg_loopback (TX stream fed into RX).
`timescale 1ns/1ps
module uart_core_p
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
`ifdef UART_LOOPBACK_EN
  input  logic                 cfg_loopback,
`endif
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_bit,
  input  logic                 rx_bit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int             OS_W     = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]     LAST_BIT = 4'(DATA_BITS - 1);

  logic w_tick;
  logic w_tx_line;
  logic w_rx_src;

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_div   (cfg_div),
    .o_tick  (w_tick)
  );

`ifdef UART_LOOPBACK_EN
  assign tx_bit   = cfg_loopback ? LINE_IDLE : w_tx_line;
  assign w_rx_src = cfg_loopback ? w_tx_line : rx_bit;
`else
  assign tx_bit   = w_tx_line;
  assign w_rx_src = rx_bit;
`endif

  tx_state_t               r_tx_state;
  tx_state_t               w_tx_state_nxt;
  logic [OS_W-1:0]         r_tx_os;
  logic [3:0]              r_tx_idx;
  logic [DATA_BITS-1:0]    r_tx_shift;
  logic [1:0]              r_tx_par_mode;
  logic                    r_tx_stop2;
  logic                    r_tx_par_bit;
  logic                    w_tx_bit_end;
  logic                    w_tx_accept;

  assign tx_ready    = (r_tx_state == TX_IDLE);
  assign tx_busy     = ~tx_ready;
  assign w_tx_accept = tx_valid && tx_ready;

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_line      = LINE_IDLE;
    w_tx_bit_end   = w_tick && (r_tx_os == OS_LAST);
    case (r_tx_state)
      TX_IDLE: begin
        if (tx_valid) w_tx_state_nxt = TX_START;
      end
      TX_START: begin
        w_tx_line = 1'b0;
        if (w_tx_bit_end) w_tx_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_bit_end && (r_tx_idx == LAST_BIT))
          w_tx_state_nxt = (r_tx_par_mode == PAR_NONE) ? TX_STOP : TX_PARITY;
      end
      TX_PARITY: begin
        w_tx_line = r_tx_par_bit;
        if (w_tx_bit_end) w_tx_state_nxt = TX_STOP;
      end
      TX_STOP: begin
        w_tx_line = LINE_IDLE;
        if (w_tx_bit_end && (!r_tx_stop2 || (r_tx_idx == 4'd1)))
          w_tx_state_nxt = TX_IDLE;
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // r_tx_idx counts data bits in DATA and stop bits in STOP; it restarts on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state    <= TX_IDLE;
      r_tx_os       <= '0;
      r_tx_idx      <= '0;
      r_tx_shift    <= '0;
      r_tx_par_mode <= PAR_NONE;
      r_tx_stop2    <= 1'b0;
      r_tx_par_bit  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      if (w_tx_accept) begin
        r_tx_shift    <= tx_data;
        r_tx_par_mode <= norm_parity(cfg_parity);
        r_tx_stop2    <= cfg_stop2;
        r_tx_par_bit  <= parity_of(9'(tx_data), cfg_parity);
        r_tx_os       <= '0;
        r_tx_idx      <= '0;
      end else if (w_tick) begin
        r_tx_os <= w_tx_bit_end ? '0 : r_tx_os + OS_W'(1);
        if (w_tx_bit_end) begin
          r_tx_idx <= (w_tx_state_nxt != r_tx_state) ? 4'd0 : r_tx_idx + 4'd1;
          if (r_tx_state == TX_DATA) r_tx_shift <= r_tx_shift >> 1;
        end
      end
    end
  end

  logic [1:0]           r_sync;
  logic                 w_rx_in;
  rx_state_t            r_rx_state;
  rx_state_t            w_rx_state_nxt;
  logic [OS_W-1:0]      r_rx_os;
  logic [3:0]           r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [1:0]           r_rx_par_mode;
  logic                 r_rx_perr;
  logic                 w_rx_sample;
  logic                 w_rx_done;
  logic                 w_rx_ferr;

  assign w_rx_in = r_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= {2{LINE_IDLE}};
    else        r_sync <= {r_sync[0], w_rx_src};
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_done      = 1'b0;
    w_rx_ferr      = 1'b0;
    w_rx_sample    = w_tick && (r_rx_os == ((r_rx_state == RX_START) ? OS_HALF : OS_LAST));
    case (r_rx_state)
      RX_IDLE: begin
        if (w_rx_in != LINE_IDLE) w_rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (w_rx_sample)
          w_rx_state_nxt = (w_rx_in == LINE_IDLE) ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (w_rx_sample && (r_rx_idx == LAST_BIT))
          w_rx_state_nxt = (r_rx_par_mode == PAR_NONE) ? RX_STOP : RX_PARITY;
      end
      RX_PARITY: begin
        if (w_rx_sample) w_rx_state_nxt = RX_STOP;
      end
      RX_STOP: begin
        if (w_rx_sample) begin
          w_rx_done = 1'b1;
          if (w_rx_in == LINE_IDLE) begin
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_rx_ferr      = 1'b1;
            w_rx_state_nxt = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (w_rx_in == LINE_IDLE) w_rx_state_nxt = RX_IDLE;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // Start detect zeroes the phase counter so the START sample lands mid start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state    <= RX_IDLE;
      r_rx_os       <= '0;
      r_rx_idx      <= '0;
      r_rx_shift    <= '0;
      r_rx_par_mode <= PAR_NONE;
      r_rx_perr     <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      if ((r_rx_state == RX_IDLE) && (w_rx_state_nxt == RX_START)) begin
        r_rx_os       <= '0;
        r_rx_idx      <= '0;
        r_rx_par_mode <= norm_parity(cfg_parity);
        r_rx_perr     <= 1'b0;
      end else if (w_tick) begin
        r_rx_os <= w_rx_sample ? '0 : r_rx_os + OS_W'(1);
        if (w_rx_sample) begin
          r_rx_idx <= (w_rx_state_nxt != r_rx_state) ? 4'd0 : r_rx_idx + 4'd1;
          if (r_rx_state == RX_DATA)
            r_rx_shift <= {w_rx_in, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_state == RX_PARITY)
            r_rx_perr <= (w_rx_in != parity_of(9'(r_rx_shift), r_rx_par_mode));
        end
      end
    end
  end

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_rx_perr_hold;
  logic                 r_rx_ferr_hold;
  logic                 r_rx_overrun;

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_parity_err = r_rx_perr_hold;
  assign rx_frame_err  = r_rx_ferr_hold;
  assign rx_overrun    = r_rx_overrun;

  // A consumer taking the old word in the completion cycle makes room for the new one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rx_perr_hold <= 1'b0;
      r_rx_ferr_hold <= 1'b0;
      r_rx_overrun   <= 1'b0;
    end else begin
      r_rx_overrun <= 1'b0;
      if (w_rx_done) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data      <= r_rx_shift;
          r_rx_valid     <= 1'b1;
          r_rx_perr_hold <= r_rx_perr;
          r_rx_ferr_hold <= w_rx_ferr;
        end else begin
          r_rx_overrun <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid     <= 1'b0;
        r_rx_perr_hold <= 1'b0;
        r_rx_ferr_hold <= 1'b0;
      end
    end
  end

endmodule
